// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared encodings for the elevator car datapath
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_STOP   = 2'b00,
    DIR_DOWN   = 2'b01,
    DIR_UP     = 2'b10,
    DIR_UPDOWN = 2'b11
  } dir_e;

  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;
  localparam logic OPEN  = 1'b1;
  localparam logic CLOSE = 1'b0;
  localparam logic MOVE  = 1'b1;
  localparam logic HOLD  = 1'b0;

  localparam int         NUM_FLOORS   = 7;
  localparam logic [2:0] BOTTOM_FLOOR = 3'd1;
  localparam logic [2:0] TOP_FLOOR    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_TRAVEL = 2'b01,
    ST_ARRIVE = 2'b10
  } state_e;

endpackage

// File: rtl/car_motion_controller_if.sv
// rtl/car_motion_controller_if.sv - request/status bundle between car motion controller and its neighbours
interface car_motion_controller_if;
  logic        enable;
  logic [1:0]  nextDirection;
  logic        doorState;
  logic [13:0] floorButton;
  logic [7:1]  internalButton;
  logic [2:0]  currentFloor;
  logic [1:0]  currentDirection;
  logic        move;
  logic        arrived;

  modport master (
    output enable, nextDirection, doorState, floorButton, internalButton,
    input  currentFloor, currentDirection, move, arrived
  );

  modport slave (
    input  enable, nextDirection, doorState, floorButton, internalButton,
    output currentFloor, currentDirection, move, arrived
  );
endinterface

// File: rtl/floor_request_decoder.sv
// rtl/floor_request_decoder.sv - decides whether the car stops at a floor given the pending calls
module floor_request_decoder
  import elevator_pkg::*;
(
  input  logic [2:0]  floor,
  input  logic [1:0]  dir,
  input  logic [13:0] floorButton,
  input  logic [7:1]  internalButton,
  output logic        stopHere,
  output logic        anyAhead
);

  logic car_here;
  logic hall_here;

  always_comb begin
    car_here  = 1'b0;
    hall_here = 1'b0;
    anyAhead  = 1'b0;
    for (int g = 1; g <= NUM_FLOORS; g++) begin
      if (3'(g) == floor) begin
        car_here  = internalButton[g];
        hall_here = (dir == DIR_UP)   ? floorButton[2*g-1] :
                    (dir == DIR_DOWN) ? floorButton[2*g-2] : 1'b0;
      end
      // Either hall bit counts as a reason to keep going past this floor
      if ((dir == DIR_UP && 3'(g) > floor) || (dir == DIR_DOWN && 3'(g) < floor))
        anyAhead |= internalButton[g] | floorButton[2*g-1] | floorButton[2*g-2];
    end
  end

  assign stopHere = car_here | hall_here | ~anyAhead
                  | (dir == DIR_UP   && floor == TOP_FLOOR)
                  | (dir == DIR_DOWN && floor == BOTTOM_FLOOR);

endmodule

// File: rtl/car_motion_controller.sv
// rtl/car_motion_controller.sv - owns car floor/direction/motion state and times floor-to-floor travel
module car_motion_controller
  import elevator_pkg::*;
#(
  parameter int FLOOR_TICKS = 8,
  parameter int HOLD_TICKS  = 4,
  parameter int TIMER_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  car_motion_controller_if.slave    bus
);

  localparam logic [TIMER_W-1:0] FLOOR_LAST = TIMER_W'(FLOOR_TICKS - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_TICKS - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]           floor_q, floor_d;
  logic [1:0]           dir_q, dir_d;
  logic                 move_q, move_d;
  logic                 arrived_q, arrived_d;

  logic [2:0]           next_floor;
  logic                 stop_here;
  logic                 any_ahead;
  logic                 stop_now;
  logic                 can_depart;

  // Clamped so a corrupted direction can never push the floor outside 1..7
  always_comb begin
    next_floor = floor_q;
    if (dir_q == DIR_UP && floor_q != TOP_FLOOR)
      next_floor = floor_q + 3'd1;
    else if (dir_q == DIR_DOWN && floor_q != BOTTOM_FLOOR)
      next_floor = floor_q - 3'd1;
  end

  floor_request_decoder u_decoder (
    .floor          (next_floor),
    .dir            (dir_q),
    .floorButton    (bus.floorButton),
    .internalButton (bus.internalButton),
    .stopHere       (stop_here),
    .anyAhead       (any_ahead)
  );

  assign stop_now   = stop_here | ~any_ahead;
  assign can_depart = (bus.nextDirection == DIR_UP   && floor_q != TOP_FLOOR) ||
                      (bus.nextDirection == DIR_DOWN && floor_q != BOTTOM_FLOOR);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    move_d    = move_q;
    arrived_d = 1'b0;
    if (bus.enable) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.nextDirection != DIR_UPDOWN && bus.doorState == CLOSE) begin
            if (can_depart) begin
              dir_d   = bus.nextDirection;
              move_d  = MOVE;
              timer_d = '0;
              state_d = ST_TRAVEL;
            end else begin
              dir_d = DIR_STOP;
            end
          end
        end
        ST_TRAVEL: begin
          if (timer_q == FLOOR_LAST) begin
            floor_d = next_floor;
            timer_d = '0;
            if (stop_now) begin
              move_d    = HOLD;
              arrived_d = 1'b1;
              state_d   = ST_ARRIVE;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_ARRIVE: begin
          if (timer_q == HOLD_LAST) begin
            timer_d = '0;
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      floor_q   <= BOTTOM_FLOOR;
      dir_q     <= DIR_STOP;
      move_q    <= HOLD;
      arrived_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      move_q    <= move_d;
      arrived_q <= arrived_d;
    end
  end

  assign bus.currentFloor     = floor_q;
  assign bus.currentDirection = dir_q;
  assign bus.move             = move_q;
  assign bus.arrived          = arrived_q;

endmodule

// File: tb/tb_car_motion_controller.sv
// tb/tb_car_motion_controller.sv - directed and randomized checks of the car motion controller
module tb_car_motion_controller;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  car_motion_controller_if bus();

  car_motion_controller #(.FLOOR_TICKS(8), .HOLD_TICKS(4), .TIMER_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int          cur, stop_f, need, n_en;
  bit          got, en;
  logic [1:0]  d;
  logic [13:0] fb;
  logic [7:1]  ib;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.nextDirection = DIR_STOP;
    bus.doorState = CLOSE;
    bus.floorButton = '0;
    bus.internalButton = '0;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic depart(input logic [1:0] dd);
    bus.nextDirection = dd;
    tick();
    bus.nextDirection = DIR_STOP;
  endtask

  // Walk floors in travel direction and apply the stopping rule directly
  function automatic int model_stop(input int start, input logic [1:0] dd,
                                    input logic [13:0] f_b, input logic [7:1] i_b);
    int  step;
    bit  ahead;
    step = (dd == DIR_UP) ? 1 : -1;
    for (int f = start + step; f >= 1 && f <= 7; f += step) begin
      ahead = 1'b0;
      for (int g = f + step; g >= 1 && g <= 7; g += step)
        if (i_b[g] || f_b[2*g-1] || f_b[2*g-2]) ahead = 1'b1;
      if (i_b[f] || ((dd == DIR_UP) ? f_b[2*f-1] : f_b[2*f-2]) || !ahead || f == 7 || f == 1)
        return f;
    end
    return start;
  endfunction

  initial begin
    do_reset();
    chk("rst_floor", bus.currentFloor, 1);
    chk("rst_dir", bus.currentDirection, DIR_STOP);
    chk("rst_move", bus.move, 0);
    chk("rst_arrived", bus.arrived, 0);

    // Basic trip 1 -> 3, hold, then continue upward with nothing pending
    bus.internalButton[3] = 1'b1;
    depart(DIR_UP);
    chk("s2_dep_move", bus.move, 1);
    chk("s2_dep_dir", bus.currentDirection, DIR_UP);
    ticks(7);
    chk("s2_floor1_c7", bus.currentFloor, 1);
    tick();
    chk("s2_floor2_c8", bus.currentFloor, 2);
    chk("s2_move_c8", bus.move, 1);
    ticks(7);
    chk("s2_no_arr_c15", bus.arrived, 0);
    tick();
    chk("s2_floor3_c16", bus.currentFloor, 3);
    chk("s2_arr_c16", bus.arrived, 1);
    chk("s2_move_c16", bus.move, 0);
    chk("s2_dir_c16", bus.currentDirection, DIR_UP);
    tick();
    chk("s2_arr_pulse", bus.arrived, 0);
    bus.nextDirection = DIR_UP;
    ticks(3);
    chk("s2_arrive_ignores", bus.move, 0);
    tick();
    chk("s2_idle_at_4", bus.move, 1);
    bus.internalButton = '0;
    bus.nextDirection = DIR_STOP;
    ticks(8);
    chk("s2_noahead_floor", bus.currentFloor, 4);
    chk("s2_noahead_arr", bus.arrived, 1);

    // Reset while travelling through floor 3
    do_reset();
    bus.internalButton[7] = 1'b1;
    depart(DIR_UP);
    ticks(20);
    chk("s1_pre_floor", bus.currentFloor, 3);
    chk("s1_pre_move", bus.move, 1);
    #2 reset = 1'b1;
    #1;
    chk("s1_async_floor", bus.currentFloor, 1);
    chk("s1_async_dir", bus.currentDirection, DIR_STOP);
    chk("s1_async_move", bus.move, 0);
    chk("s1_async_arr", bus.arrived, 0);
    #2 reset = 1'b0;
    bus.internalButton = '0;
    ticks(4);
    chk("s1_stay_move", bus.move, 0);
    chk("s1_stay_floor", bus.currentFloor, 1);

    // Passes a DOWN hall call while going up
    do_reset();
    bus.floorButton[7:6] = 2'b01;
    bus.internalButton[6] = 1'b1;
    depart(DIR_UP);
    ticks(24);
    chk("s3_pass4_floor", bus.currentFloor, 4);
    chk("s3_pass4_move", bus.move, 1);
    ticks(15);
    chk("s3_c39_arr", bus.arrived, 0);
    tick();
    chk("s3_c40_floor", bus.currentFloor, 6);
    chk("s3_c40_arr", bus.arrived, 1);

    // Stops at last pending call even though it is the opposite direction
    do_reset();
    bus.floorButton[9:8] = 2'b01;
    depart(DIR_UP);
    ticks(31);
    chk("s4_c31_arr", bus.arrived, 0);
    tick();
    chk("s4_floor", bus.currentFloor, 5);
    chk("s4_arr", bus.arrived, 1);
    chk("s4_dir", bus.currentDirection, DIR_UP);

    // Top floor refusal and door interlock
    do_reset();
    bus.internalButton[7] = 1'b1;
    depart(DIR_UP);
    ticks(48);
    chk("s5_top_floor", bus.currentFloor, 7);
    ticks(4);
    bus.nextDirection = DIR_UP;
    tick();
    chk("s5_top_move", bus.move, 0);
    chk("s5_top_dir", bus.currentDirection, DIR_STOP);
    bus.doorState = OPEN;
    bus.nextDirection = DIR_DOWN;
    ticks(3);
    chk("s5_open_move", bus.move, 0);
    chk("s5_open_dir", bus.currentDirection, DIR_STOP);
    bus.doorState = CLOSE;
    tick();
    chk("s5_close_move", bus.move, 1);
    chk("s5_close_dir", bus.currentDirection, DIR_DOWN);
    bus.internalButton = '0;
    bus.nextDirection = DIR_STOP;
    ticks(8);
    chk("s5_down_floor", bus.currentFloor, 6);
    chk("s5_down_arr", bus.arrived, 1);

    // Clock-enable freeze mid-travel
    do_reset();
    bus.internalButton[3] = 1'b1;
    depart(DIR_UP);
    ticks(5);
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s6_frozen_move", bus.move, 1);
      chk("s6_frozen_floor", bus.currentFloor, 1);
    end
    bus.enable = 1'b1;
    ticks(10);
    chk("s6_c20_floor", bus.currentFloor, 2);
    chk("s6_c20_arr", bus.arrived, 0);
    tick();
    chk("s6_c21_floor", bus.currentFloor, 3);
    chk("s6_c21_arr", bus.arrived, 1);
    bus.enable = 1'b0;
    tick();
    chk("s6_no_stretch", bus.arrived, 0);
    bus.enable = 1'b1;
    ticks(4);
    bus.nextDirection = DIR_UPDOWN;
    ticks(2);
    chk("updown_dir_hold", bus.currentDirection, DIR_UP);
    chk("updown_move", bus.move, 0);
    bus.nextDirection = DIR_STOP;
    tick();
    chk("stop_clears_dir", bus.currentDirection, DIR_STOP);

    // Randomized trips with random enable gaps against the floor-walk model
    do_reset();
    cur = 1;
    for (int t = 0; t < 24; t++) begin
      if (cur == 1) d = DIR_UP;
      else if (cur == 7) d = DIR_DOWN;
      else d = ($urandom_range(0, 1) == 0) ? DIR_UP : DIR_DOWN;
      fb = 14'($urandom) & 14'($urandom) & 14'($urandom);
      ib = 7'($urandom) & 7'($urandom);
      bus.floorButton = fb;
      bus.internalButton = ib;
      bus.enable = 1'b1;
      depart(d);
      chk("rnd_dep_move", bus.move, 1);
      stop_f = model_stop(cur, d, fb, ib);
      need = 8 * ((stop_f > cur) ? stop_f - cur : cur - stop_f);
      n_en = 0;
      got = 1'b0;
      for (int c = 0; c < 600 && !got; c++) begin
        en = ($urandom_range(0, 3) != 0);
        bus.enable = en;
        tick();
        if (en) n_en++;
        if (bus.arrived === 1'b1) begin
          got = 1'b1;
          chk("rnd_floor", bus.currentFloor, stop_f);
          chk("rnd_cycles", n_en, need);
          chk("rnd_dir", bus.currentDirection, d);
          chk("rnd_move", bus.move, 0);
        end
      end
      if (!got) chk("rnd_timeout", 0, 1);
      bus.enable = 1'b1;
      ticks(4);
      cur = stop_f;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/car_motion_controller.md
Name: car_motion_controller

Overview:
Downstream of the direction-decision stage. Consumes the registered `nextDirection` and owns the car's physical state. It produces `currentFloor`, `currentDirection` and `move`, and these feed back into the direction-decision stage and the door controller. The block times floor-to-floor travel, decides at each floor whether to stop, and pulses `arrived` to the door controller.

Parameters:
- FLOOR_TICKS, 8, enabled clock cycles to travel one floor; must be ≥ 2.
- HOLD_TICKS, 4, enabled cycles spent in ARRIVE before the block may depart again; must be ≥ 1.
- TIMER_W, 8, timer width; must satisfy 2^TIMER_W > max(FLOOR_TICKS, HOLD_TICKS).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  clock enable; when low, all state and outputs hold
- nextDirection  in  2  requested direction from the decision stage: STOP=00, UP=10, DOWN=01, UPDOWN=11 (illegal)
- doorState  in  1  OPEN=1, CLOSE=0
- floorButton  in  14  hall calls; floor f uses bits [2f-1:2f-2]; UP=10, DOWN=01, both=11
- internalButton  in  7 [7:1]  car calls, one bit per floor
- currentFloor  out  3  registered floor, range 1..7
- currentDirection  out  2  registered travel direction, same encoding as nextDirection
- move  out  1  MOVE=1, HOLD=0
- arrived  out  1  one-cycle pulse on the edge the car stops at a floor

Behaviour:
- Reset is asynchronous and active-high. Every reset, including one mid-travel, forces: currentFloor=1, currentDirection=STOP, move=0, arrived=0, timer=0, state=IDLE.
- All transitions below require enable=1. With enable=0, the state, timer and outputs all hold; arrived is forced to 0 and does not stretch.
- arrived defaults to 0 every enabled cycle unless set as described below.
- FSM states: IDLE, TRAVEL, ARRIVE.
- IDLE (move=0):
  - Departure requires doorState==CLOSE and one of: nextDirection==UP with currentFloor<7, or nextDirection==DOWN with currentFloor>1.
  - On departure: currentDirection<=nextDirection, move<=1, timer<=0, state<=TRAVEL. Departure latency is 1 cycle.
  - If nextDirection is STOP, or is UP/DOWN at an end floor: currentDirection<=STOP; stay in IDLE.
  - UPDOWN: ignored, all state holds.
  - doorState==OPEN: no departure; currentDirection holds.
- TRAVEL (move=1):
  - timer increments each enabled cycle.
  - When timer==FLOOR_TICKS-1: currentFloor<=currentFloor±1 per currentDirection, timer<=0, and evaluate stopHere for the new floor f.
  - stopHere = internalButton[f] | (direction-matching hall bit of f) | !anyAhead(f, dir) | (f==7 going UP) | (f==1 going DOWN).
    - Direction-matching hall bit: bit 2f-1 when going UP, bit 2f-2 when going DOWN.
    - anyAhead is any car call or hall call (either bit) strictly beyond f in the travel direction.
  - stopHere=1: move<=0, arrived<=1, timer<=0, state<=ARRIVE. currentDirection is retained.
  - stopHere=0: stay in TRAVEL.
  - Button inputs are sampled only on the floor-crossing cycle.
- ARRIVE (move=0):
  - timer counts HOLD_TICKS enabled cycles, then timer<=0, state<=IDLE.
  - nextDirection is ignored during ARRIVE. This gives the door controller time to react to arrived.
- currentFloor never leaves 1..7. A floor change and arrived occur on the same edge.
- Floor-to-floor time is exactly FLOOR_TICKS enabled cycles.

Decomposition:
- Package elevator_pkg holds:
  - direction encodings STOP/UP/DOWN/UPDOWN
  - ON/OFF, OPEN/CLOSE, MOVE/HOLD
  - NUM_FLOORS=7, BOTTOM_FLOOR=1, TOP_FLOOR=7
  - FSM state encoding
- Combinational sub-module floor_request_decoder:
  - inputs: floor, dir, floorButton, internalButton
  - outputs: stopHere, anyAhead
- The FSM, timer and output registers stay in car_motion_controller.

Test Plan:
1. Assert reset mid-TRAVEL near floor 3 → same instant: currentFloor=1, currentDirection=STOP, move=0, arrived=0. After release, the block stays in IDLE with nextDirection=STOP.
2. Floor 1, door CLOSE, internalButton[3]=1, nextDirection=UP → next edge: move=1, dir=UP. Floor=2 after 8 cycles. Floor=3 plus one-cycle arrived and move=0 after 16 cycles. IDLE after 4 further cycles.
3. Floor 1 going UP; floorButton[7:6]=01 (floor 4 DOWN) and internalButton[6]=1 → passes floor 4 without stopping; stops at floor 6 at cycle 40.
4. Floor 1 going UP; only floorButton[9:8]=01 (floor 5 DOWN) → stops at 5 via !anyAhead; currentDirection stays UP, arrived=1.
5. Floor 7 with nextDirection=UP, and separately doorState=OPEN with nextDirection=DOWN → no departure, move stays 0. The first gives currentDirection=STOP. The second departs 1 cycle after doorState goes CLOSE.
6. enable=0 for 5 cycles mid-TRAVEL → timer and outputs frozen; the arrival in scenario 2 is delayed to exactly cycle 21.
